// File: rtl/filt_pkg.sv
// rtl/filt_pkg.sv - Shared state encoding and default PLL sequencing parameters for the interpolation filter
package filt_pkg;

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } pll_state_t;

    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 4096;
    localparam int DEF_STABLE_CYCLES = 64;
    localparam int DEF_MAX_RETRIES   = 3;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - Generic two-flop synchronizer, async active-low reset to 0
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_seq.sv
// rtl/pll_reset_seq.sv - PLL reset/lock sequencer: holds PLL in reset, qualifies lock, releases datapath reset
module pll_reset_seq
    import filt_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       LOCKED,
    input  logic       RESTART,
    output logic       PLL_RST,
    output logic       SYS_RST_N,
    output logic       READY,
    output logic       FAULT,
    output logic [3:0] RETRY_CNT,
    output logic [7:0] LOSS_CNT
);

    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

    logic          lock_s;
    pll_state_t    state, state_n;
    logic [RW-1:0] rst_cnt, rst_cnt_n;
    logic [TW-1:0] to_cnt, to_cnt_n;
    logic [SW-1:0] st_cnt, st_cnt_n;
    logic [3:0]    retry_n;
    logic [7:0]    loss_n;

    sync2 u_lock_sync (
        .clk   (CLK),
        .rst_n (RST_N),
        .d     (LOCKED),
        .q     (lock_s)
    );

    always_comb begin
        state_n   = state;
        rst_cnt_n = rst_cnt;
        to_cnt_n  = to_cnt;
        st_cnt_n  = st_cnt;
        retry_n   = RETRY_CNT;
        loss_n    = LOSS_CNT;
        if (RESTART) begin
            state_n   = ST_HOLD;
            rst_cnt_n = '0;
            to_cnt_n  = '0;
            st_cnt_n  = '0;
            retry_n   = '0;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (rst_cnt == RW'(RST_CYCLES - 1)) begin
                        state_n   = ST_WAIT_LOCK;
                        rst_cnt_n = '0;
                        to_cnt_n  = '0;
                    end else begin
                        rst_cnt_n = rst_cnt + RW'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_n  = ST_STABLE;
                        st_cnt_n = '0;
                    end else if (to_cnt == TW'(LOCK_TIMEOUT - 1)) begin
                        retry_n   = RETRY_CNT + 4'd1;
                        to_cnt_n  = '0;
                        rst_cnt_n = '0;
                        state_n   = (retry_n == 4'(MAX_RETRIES)) ? ST_FAULT : ST_HOLD;
                    end else begin
                        to_cnt_n = to_cnt + TW'(1);
                    end
                end
                // Any dropout restarts qualification; it does not count as a retry.
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_n  = ST_WAIT_LOCK;
                        to_cnt_n = '0;
                    end else if (st_cnt == SW'(STABLE_CYCLES - 1)) begin
                        state_n = ST_RUN;
                        retry_n = '0;
                    end else begin
                        st_cnt_n = st_cnt + SW'(1);
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_n   = ST_HOLD;
                        rst_cnt_n = '0;
                        if (LOSS_CNT != 8'hFF) begin
                            loss_n = LOSS_CNT + 8'd1;
                        end
                    end
                end
                ST_FAULT: begin
                end
                default: begin
                    state_n   = ST_HOLD;
                    rst_cnt_n = '0;
                end
            endcase
        end
    end

    // Outputs are registered decodes of the next state so they switch on the same edge as the state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ST_HOLD;
            rst_cnt   <= '0;
            to_cnt    <= '0;
            st_cnt    <= '0;
            RETRY_CNT <= '0;
            LOSS_CNT  <= '0;
            PLL_RST   <= 1'b1;
            SYS_RST_N <= 1'b0;
            READY     <= 1'b0;
            FAULT     <= 1'b0;
        end else begin
            state     <= state_n;
            rst_cnt   <= rst_cnt_n;
            to_cnt    <= to_cnt_n;
            st_cnt    <= st_cnt_n;
            RETRY_CNT <= retry_n;
            LOSS_CNT  <= loss_n;
            PLL_RST   <= (state_n == ST_HOLD) || (state_n == ST_FAULT);
            SYS_RST_N <= (state_n == ST_RUN);
            READY     <= (state_n == ST_RUN);
            FAULT     <= (state_n == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb/tb_pll_reset_seq.sv - Scoreboard bench for pll_reset_seq with event-time reference model
module tb_pll_reset_seq;

    localparam int RC = 16;
    localparam int LT = 256;
    localparam int SC = 64;
    localparam int MR = 3;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       LOCKED = 1'b0;
    logic       RESTART = 1'b0;
    logic       PLL_RST, SYS_RST_N, READY, FAULT;
    logic [3:0] RETRY_CNT;
    logic [7:0] LOSS_CNT;

    pll_reset_seq #(
        .RST_CYCLES    (RC),
        .LOCK_TIMEOUT  (LT),
        .STABLE_CYCLES (SC),
        .MAX_RETRIES   (MR)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .LOCKED    (LOCKED),
        .RESTART   (RESTART),
        .PLL_RST   (PLL_RST),
        .SYS_RST_N (SYS_RST_N),
        .READY     (READY),
        .FAULT     (FAULT),
        .RETRY_CNT (RETRY_CNT),
        .LOSS_CNT  (LOSS_CNT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct packed {
        int          t;
        logic [15:0] v;
    } ev_t;

    ev_t         evq[$];
    int          n_chk = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;
    logic [15:0] prev = 16'h8000;

    logic       m_pll = 1'b1, m_sys = 1'b0, m_ready = 1'b0, m_fault = 1'b0;
    logic [3:0] m_retry = 4'd0;
    logic [7:0] m_loss = 8'd0;

    function automatic logic [15:0] obs();
        return {PLL_RST, SYS_RST_N, READY, FAULT, RETRY_CNT, LOSS_CNT};
    endfunction

    function automatic logic [15:0] model();
        return {m_pll, m_sys, m_ready, m_fault, m_retry, m_loss};
    endfunction

    // Earliest RUN edge given WAIT_LOCK entry edge w and LOCKED rise time r.
    function automatic int run_time(input int w, input int r);
        return (((w + 1) > (r + 3)) ? (w + 1) : (r + 3)) + SC;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int t);
        ev_t e;
        e.t = t;
        e.v = model();
        evq.push_back(e);
    endtask

    task automatic ev_hold(input int t);
        m_pll = 1'b1; m_sys = 1'b0; m_ready = 1'b0;
        push(t);
    endtask

    task automatic ev_wait(input int t);
        m_pll = 1'b0;
        push(t);
    endtask

    task automatic ev_run(input int t);
        m_sys = 1'b1; m_ready = 1'b1; m_retry = 4'd0;
        push(t);
    endtask

    task automatic go(input int t);
        while (cyc < t) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic lose(input int n, output int w);
        if (m_loss != 8'hFF) m_loss = m_loss + 8'd1;
        ev_hold(n + 3);
        w = n + 3 + RC;
        ev_wait(w);
        go(n);
        LOCKED = 1'b0;
    endtask

    task automatic lock_at(input int w, input int r);
        int rt;
        rt = run_time(w, r);
        ev_run(rt);
        go(r);
        LOCKED = 1'b1;
        go(rt + 3);
    endtask

    task automatic mid_reset(input int n);
        int w;
        m_pll = 1'b1; m_sys = 1'b0; m_ready = 1'b0; m_fault = 1'b0;
        m_retry = 4'd0; m_loss = 8'd0;
        push(n);
        go(n);
        RST_N = 1'b0;
        #1;
        check("async_reset", obs(), 16'h8000);
        w = n + 3 + RC;
        ev_wait(w);
        ev_run(w + 1 + SC);
        go(n + 3);
        RST_N = 1'b1;
        go(w + 1 + SC + 3);
    endtask

    always @(negedge CLK) begin
        if (mon_en) begin
            logic [15:0] cur;
            ev_t         e;
            cur = obs();
            if (cur !== prev) begin
                n_chk++;
                if (evq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change: got %h at cycle %0d, expected no change", cur, cyc);
                end else begin
                    e = evq.pop_front();
                    if (cur !== e.v || cyc != e.t) begin
                        n_fail++;
                        $display("FAIL output_event: got %h at cycle %0d expected %h at cycle %0d",
                                 cur, cyc, e.v, e.t);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        int w, t, r, n;

        go(3);
        check("reset_state", obs(), 16'h8000);
        mon_en = 1'b1;
        RST_N = 1'b1;
        w = 3 + RC;
        ev_wait(w);
        lock_at(w, w + 100);

        for (int i = 0; i < 300; i++) begin
            n = cyc + int'($urandom_range(1, 10));
            lose(n, w);
            lock_at(w, n + int'($urandom_range(1, 30)));
        end
        check("loss_saturated", LOSS_CNT, 8'hFF);

        // One timeout, then a lock that drops out once during qualification.
        lose(cyc + 5, w);
        t = w + LT;
        m_retry = 4'd1;
        ev_hold(t);
        w = t + RC;
        ev_wait(w);
        r = w + int'($urandom_range(0, 60));
        ev_run(r + 45 + 3 + SC);
        go(r);
        LOCKED = 1'b1;
        go(r + 40);
        LOCKED = 1'b0;
        go(r + 45);
        LOCKED = 1'b1;
        go(r + 45 + 3 + SC + 3);

        // Retries exhausted, then RESTART out of FAULT.
        lose(cyc + 4, w);
        for (int k = 1; k <= MR; k++) begin
            t = w + LT;
            m_retry = m_retry + 4'd1;
            if (k == MR) begin
                m_pll = 1'b1;
                m_fault = 1'b1;
                push(t);
            end else begin
                ev_hold(t);
                w = t + RC;
                ev_wait(w);
            end
        end
        n = t + int'($urandom_range(5, 40));
        go(n);
        check("fault_held", {PLL_RST, FAULT, RETRY_CNT}, {2'b11, 4'd3});
        m_fault = 1'b0;
        m_retry = 4'd0;
        push(n + 1);
        RESTART = 1'b1;
        go(n + 1);
        RESTART = 1'b0;
        w = n + 1 + RC;
        ev_wait(w);
        lock_at(w, w + int'($urandom_range(0, 100)));

        // RESTART lands on the same edge as the final timeout.
        lose(cyc + 6, w);
        for (int k = 1; k < MR; k++) begin
            t = w + LT;
            m_retry = m_retry + 4'd1;
            ev_hold(t);
            w = t + RC;
            ev_wait(w);
        end
        t = w + LT;
        m_retry = 4'd0;
        ev_hold(t);
        w = t + RC;
        ev_wait(w);
        go(t - 1);
        RESTART = 1'b1;
        go(t);
        RESTART = 1'b0;
        check("restart_wins_fault", FAULT, 1'b0);
        lock_at(w, w + int'($urandom_range(0, 50)));

        // Reset while qualifying lock, then reset while running.
        n = cyc + 3;
        lose(n, w);
        go(n + 5);
        LOCKED = 1'b1;
        mid_reset(w + 1 + 20);
        mid_reset(cyc + 10);

        go(cyc + 20);
        check("queue_drained", evq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
